// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit packet scheduler.
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TO_DEF  = 64;
  localparam int STALL_TO_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               vld_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ requesters with packet-atomic
// round-robin grants; one byte in flight at a time.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_PKT  = 16,
  parameter int BUSY_TO  = BUSY_TO_DEF,
  parameter int STALL_TO = STALL_TO_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_TO + 1);
  localparam int BW = $clog2(BUSY_TO + 1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       gidx_q, ptr_q;
  logic [7:0]          cnt_q;
  logic                last_q, tx_start_q, err_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic [SW-1:0]       scnt_q;
  logic [BW-1:0]       bcnt_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_vld;
  logic                g_valid, g_last;
  logic [BYTE_W-1:0]   g_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];
  assign g_data  = req_data[{gidx_q, 3'b000} +: BYTE_W];

  // Ready is held off while an external user still owns the UART.
  assign req_ready   = (state_q == SEND && !tx_busy) ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      scnt_q     <= '0;
      bcnt_q     <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            scnt_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            if (g_valid) begin
              tx_data_q  <= g_data;
              last_q     <= g_last;
              cnt_q      <= cnt_q + 8'd1;
              scnt_q     <= '0;
              tx_start_q <= 1'b1;
              state_q    <= LAUNCH;
            end else if (scnt_q >= SW'(STALL_TO - 1)) begin
              err_q   <= 1'b1;
              state_q <= RELEASE;
            end else begin
              scnt_q <= scnt_q + 1'b1;
            end
          end
        end
        LAUNCH: begin
          // The launch cycle itself counts toward the busy timeout.
          bcnt_q  <= BW'(1);
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (bcnt_q >= BW'(BUSY_TO - 1)) begin
            err_q   <= 1'b1;
            state_q <= WAIT_DONE;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            scnt_q  <= '0;
            state_q <= (last_q || cnt_q == 8'(MAX_PKT)) ? RELEASE : SEND;
          end
        end
        RELEASE: begin
          grant_q <= '0;
          ptr_q   <= (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          cnt_q   <= '0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Packet scheduler that shares one UART transmitter among NUM_REQ requesters.
- Grants are round-robin and packet-atomic. The granted requester holds the transmitter until it marks a byte as last or MAX_PKT bytes have been sent.
- Sits between producer logic (status/echo/debug sources) and the UART TX datapath running at the BaudRate setting. Drives its start/data handshake and tracks its busy flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_PKT, 16, max bytes per grant before forced release (1..255)
- BUSY_TO, 64, cycles to wait for tx_busy to rise after tx_start before flagging a timeout
- STALL_TO, 4096, cycles a granted requester may hold valid low mid-packet before the grant is revoked

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of its packet
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- tx_busy  in  1  UART TX is shifting a frame
- tx_start  out  1  one-cycle pulse to launch a frame
- tx_data  out  8  byte for the UART TX; stable from the tx_start cycle until tx_busy falls
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- err_timeout  out  1  sticky; set on busy or stall timeout, cleared only by reset

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, req_ready=0, tx_start=0, tx_data=8'h00, err_timeout=0, rr pointer=0, byte count=0.
- States:
  - IDLE
    - If any req_valid, choose the first valid index at or after the rr pointer, with wrap-around.
    - Load grant and go to SEND next cycle. There is one idle cycle per arbitration.
  - SEND
    - req_ready[g] = 1 combinationally while tx_busy=0; all other req_ready bits are 0.
    - On transfer (valid&ready): latch tx_data, latch req_last into last_q, increment the byte count, go to LAUNCH.
    - If valid stays low for STALL_TO consecutive cycles: set err_timeout, go to RELEASE.
  - LAUNCH
    - tx_start=1 for exactly this cycle, then go to WAIT_BUSY.
    - Transfer-to-start latency is 1 cycle.
  - WAIT_BUSY
    - Go to WAIT_DONE when tx_busy=1.
    - If tx_busy is still 0 after BUSY_TO cycles: set err_timeout and go to WAIT_DONE anyway.
  - WAIT_DONE
    - When tx_busy=0: if last_q or count==MAX_PKT, go to RELEASE; otherwise go to SEND.
  - RELEASE
    - grant=0, rr pointer = g+1 mod NUM_REQ, count=0, go to IDLE.
- Only one byte is in flight at a time; req_ready never asserts outside SEND.
- A requester that loses arbitration keeps valid high and is never dropped. With all requesters active, it is served within NUM_REQ-1 packets.
- A forced release at MAX_PKT does not emit a last marker. The requester continues its packet in a later grant.
- Valid changes on non-granted requesters during a packet have no effect.
- If tx_busy is already high on entry to SEND (external user), SEND waits with req_ready=0. The stall counter counts only cycles where tx_busy=0 and valid=0.
- Reset asserted mid-frame aborts immediately. No tx_start is issued after reset release until a new arbitration.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, SEND, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE)
  - BYTE_W=8
  - default BUSY_TO and STALL_TO constants
- One sub-module, rr_arbiter (NUM_REQ). It is purely combinational: req vector plus pointer in, one-hot grant plus index out. The scheduler instantiates it once.

Test Plan:
- Single requester 0 sends 3 bytes A5,3C,FF with last on FF; tx model raises busy 1 cycle after start for 160 cycles. Expect 3 tx_start pulses carrying A5,3C,FF in order, then grant=0 and err_timeout=0.
- Requesters 0 and 2 both valid with 2-byte packets (11,12 / 21,22). Expect order 11,12,21,22 and grant 0001 then 0100; the next arbitration starts at pointer 3.
- MAX_PKT=4, requester 1 sends 6 bytes without last, requester 3 sends 1 byte 77. Expect bytes 1–4, then 77, then bytes 5–6.
- tx model never asserts busy. Expect tx_start, then err_timeout=1 exactly BUSY_TO cycles later, and the scheduler continues to the next byte.
- Requester 0 sends one byte without last, then drops valid. Expect err_timeout=1 and grant released after STALL_TO cycles; a waiting requester 1 is then served.
- Reset pulse asserted during WAIT_DONE. Expect all outputs at reset values in the same cycle, and no tx_start until a fresh request after rst returns high.
